// File: rtl/button_event_decoder_if.sv
// Control/event bundle between the debouncer side and the UI logic.
// master: drives en/din, reads events. slave: the decoder.
interface button_event_decoder_if;
    logic en;
    logic din;
    logic short_pulse;
    logic long_pulse;
    logic double_pulse;
    logic held;
    logic busy;

    modport master (
        output en,
        output din,
        input  short_pulse,
        input  long_pulse,
        input  double_pulse,
        input  held,
        input  busy
    );

    modport slave (
        input  en,
        input  din,
        output short_pulse,
        output long_pulse,
        output double_pulse,
        output held,
        output busy
    );
endinterface

// File: rtl/button_event_decoder.sv
// Classifies debounced button presses into short/long/double events.
// Ports: clk, rst_ (async, active-low), bus (en, din in; pulses, held, busy out).
module button_event_decoder #(
    parameter int LONG_CYC    = 10_000_000,
    parameter int DBL_GAP_CYC = 2_500_000,
    parameter int CNT_W       = 24
) (
    input  logic                   clk,
    input  logic                   rst_,
    button_event_decoder_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        PRESS1,
        GAP,
        PRESS2,
        LONG_HELD
    } state_t;

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] LONG_N = CNT_W'(LONG_CYC);
    localparam logic [CNT_W-1:0] GAP_N  = CNT_W'(DBL_GAP_CYC);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             din_q;
    logic             rise;
    logic             fall;
    logic             short_q;
    logic             long_q;
    logic             double_q;
    logic             held_q;
    logic             busy_q;

    assign rise = bus.din & ~din_q;
    assign fall = ~bus.din & din_q;

    // Saturating increment: the count never wraps back below a threshold.
    always_comb begin
        cnt_inc = cnt;
        if (!(&cnt)) begin
            cnt_inc = cnt + ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state    <= IDLE;
            cnt      <= '0;
            din_q    <= 1'b0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            held_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // din_q tracks din even while disabled, so a button already
            // down when en rises is not seen as a new press.
            din_q    <= bus.din;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            if (!bus.en) begin
                state  <= IDLE;
                cnt    <= '0;
                held_q <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (rise) begin
                            state  <= PRESS1;
                            cnt    <= ONE;
                            busy_q <= 1'b1;
                        end
                    end
                    PRESS1: begin
                        if (fall) begin
                            state <= GAP;
                            cnt   <= ONE;
                        end else if (cnt_inc == LONG_N) begin
                            state  <= LONG_HELD;
                            cnt    <= '0;
                            long_q <= 1'b1;
                            held_q <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    GAP: begin
                        if (rise) begin
                            state <= PRESS2;
                            cnt   <= ONE;
                        end else if (cnt_inc == GAP_N) begin
                            state   <= IDLE;
                            cnt     <= '0;
                            short_q <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    PRESS2: begin
                        if (fall) begin
                            state    <= IDLE;
                            cnt      <= '0;
                            double_q <= 1'b1;
                            busy_q   <= 1'b0;
                        end else if (cnt_inc == LONG_N) begin
                            // A long second press overrides the pending double.
                            state  <= LONG_HELD;
                            cnt    <= '0;
                            long_q <= 1'b1;
                            held_q <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    LONG_HELD: begin
                        if (fall) begin
                            state  <= IDLE;
                            cnt    <= '0;
                            held_q <= 1'b0;
                            busy_q <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        cnt    <= '0;
                        held_q <= 1'b0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.short_pulse  = short_q;
    assign bus.long_pulse   = long_q;
    assign bus.double_pulse = double_q;
    assign bus.held         = held_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder with LONG_CYC=8, DBL_GAP_CYC=4.
// Vector table feeds a scoreboard queue checked after each clock edge.
module tb_button_event_decoder;

    // Output vector order: {short, long, double, held, busy}
    localparam logic [4:0] O_IDLE  = 5'b00000;
    localparam logic [4:0] O_BUSY  = 5'b00001;
    localparam logic [4:0] O_SHORT = 5'b10000;
    localparam logic [4:0] O_LONG  = 5'b01011;
    localparam logic [4:0] O_HELD  = 5'b00011;
    localparam logic [4:0] O_DBL   = 5'b00100;

    typedef struct {
        logic       en;
        logic       din;
        int         n;
        logic [4:0] exp;
    } vec_t;

    logic clk;
    logic rst_;
    int   n_tests;
    int   n_fail;
    int   cyc;

    vec_t       tbl[$];
    logic [4:0] sb[$];

    button_event_decoder_if bus();

    button_event_decoder #(
        .LONG_CYC    (8),
        .DBL_GAP_CYC (4),
        .CNT_W       (4)
    ) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] outs();
        return {bus.short_pulse, bus.long_pulse, bus.double_pulse,
                bus.held, bus.busy};
    endfunction

    task automatic check(input string name, input logic [4:0] got,
                         input logic [4:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, got, exp);
        end
    endtask

    // Monitor: one expected vector per edge, compared 1 ns after it.
    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0) begin
            logic [4:0] e;
            e = sb.pop_front();
            check($sformatf("cyc%0d outs", cyc), outs(), e);
        end
    end

    function automatic void add(input logic en, input logic din,
                                input int n, input logic [4:0] exp);
        vec_t v;
        v.en  = en;
        v.din = din;
        v.n   = n;
        v.exp = exp;
        tbl.push_back(v);
    endfunction

    task automatic run_table();
        foreach (tbl[i]) begin
            for (int k = 0; k < tbl[i].n; k++) begin
                @(negedge clk);
                bus.en  = tbl[i].en;
                bus.din = tbl[i].din;
                sb.push_back(tbl[i].exp);
            end
        end
        tbl.delete();
    endtask

    task automatic drain();
        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(negedge clk);
        end
        if (sb.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: %0d pending, expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        rst_    = 1'b0;
        bus.en  = 1'b0;
        bus.din = 1'b1;
        #12;
        check("reset_state", outs(), O_IDLE);
        @(negedge clk);
        rst_ = 1'b1;

        // Button held through reset: no rise, no events.
        add(0, 1, 2, O_IDLE);
        add(1, 1, 20, O_IDLE);
        add(1, 0, 1, O_IDLE);
        // Short press: 3 high, 4 low.
        add(1, 1, 3, O_BUSY);
        add(1, 0, 3, O_BUSY);
        add(1, 0, 1, O_SHORT);
        add(1, 0, 2, O_IDLE);
        // Long press: 8 high then release.
        add(1, 1, 7, O_BUSY);
        add(1, 1, 1, O_LONG);
        add(1, 1, 5, O_HELD);
        add(1, 0, 1, O_IDLE);
        add(1, 0, 6, O_IDLE);
        // Double press.
        add(1, 1, 2, O_BUSY);
        add(1, 0, 2, O_BUSY);
        add(1, 1, 2, O_BUSY);
        add(1, 0, 1, O_DBL);
        add(1, 0, 6, O_IDLE);
        // Second press turns long: no double.
        add(1, 1, 2, O_BUSY);
        add(1, 0, 3, O_BUSY);
        add(1, 1, 7, O_BUSY);
        add(1, 1, 1, O_LONG);
        add(1, 1, 2, O_HELD);
        add(1, 0, 1, O_IDLE);
        add(1, 0, 5, O_IDLE);
        // Gap of exactly 4 closes the window, next press starts fresh.
        add(1, 1, 2, O_BUSY);
        add(1, 0, 3, O_BUSY);
        add(1, 0, 1, O_SHORT);
        add(1, 1, 2, O_BUSY);
        add(1, 0, 3, O_BUSY);
        add(1, 0, 1, O_SHORT);
        add(1, 0, 1, O_IDLE);
        // LONG_CYC-1 high samples stays short.
        add(1, 1, 7, O_BUSY);
        add(1, 0, 3, O_BUSY);
        add(1, 0, 1, O_SHORT);
        add(1, 0, 2, O_IDLE);
        // en dropped mid-PRESS1; held button gives no new rise.
        add(1, 1, 2, O_BUSY);
        add(0, 1, 1, O_IDLE);
        add(1, 1, 3, O_IDLE);
        add(1, 0, 6, O_IDLE);
        // en low on the edge the short event would fire: suppressed.
        add(1, 1, 2, O_BUSY);
        add(1, 0, 3, O_BUSY);
        add(0, 0, 1, O_IDLE);
        add(1, 0, 6, O_IDLE);
        // Into GAP ahead of an asynchronous reset.
        add(1, 1, 2, O_BUSY);
        add(1, 0, 2, O_BUSY);
        run_table();
        drain();

        @(posedge clk);
        #3;
        rst_ = 1'b0;
        #1;
        check("async_reset_mid_gap", outs(), O_IDLE);
        @(negedge clk);
        @(negedge clk);
        rst_ = 1'b1;
        add(1, 0, 10, O_IDLE);
        add(1, 1, 2, O_BUSY);
        add(1, 0, 3, O_BUSY);
        add(1, 0, 1, O_SHORT);
        add(1, 0, 2, O_IDLE);
        run_table();
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Sits directly downstream of the push-button debouncer and consumes its clean level output.
- Classifies each press into exactly one event: short press, long press or double press.
- Each event is a single-cycle pulse. A level flag tracks an ongoing long hold.
- Feeds the UI/control logic. Assumes a 10 MHz clock (defaults: 1 s long, 250 ms double gap).

Parameters:
LONG_CYC, 10_000_000, consecutive high samples of din that qualify a long press; must be >= 2.
DBL_GAP_CYC, 2_500_000, consecutive low samples after a release that close the double-press window; must be >= 2.
CNT_W, 24, shared counter width; must hold max(LONG_CYC, DBL_GAP_CYC).

Ports:
clk  input  1  system clock, rising-edge.
rst_  input  1  asynchronous active-low reset.
en  input  1  block enable; low forces idle.
din  input  1  debounced button level, 1 = pressed.
short_pulse  output  1  one-cycle pulse: single short press completed.
long_pulse  output  1  one-cycle pulse: press reached LONG_CYC samples.
double_pulse  output  1  one-cycle pulse: two short presses within the gap.
held  output  1  high while a long press is still held.
busy  output  1  high whenever the FSM is not IDLE.

Behaviour:
- Reset and outputs:
  - One clock (clk). Reset via rst_ is asynchronous and active-low.
  - On reset: FSM=IDLE, counter=0, din_q=0, and all outputs=0.
  - All outputs are registered. No combinational path from din to any output.
- Edge detection and pulse rules:
  - din_q is din registered. rise = din & ~din_q; fall = ~din & din_q.
  - A "sample" is the value of din at a rising clk edge.
  - At most one of short_pulse, long_pulse, double_pulse is high in any cycle.
  - Each pulse lasts exactly one cycle.
- FSM states: IDLE, PRESS1, GAP, PRESS2, LONG_HELD.
  - IDLE: on rise, go to PRESS1 with counter=1 (the rise sample counts as the first high sample).
  - PRESS1, din high: counter++. When the high-sample count reaches LONG_CYC, assert long_pulse the next cycle and go to LONG_HELD.
  - PRESS1, fall: go to GAP with counter=1 (the first low sample).
  - GAP, din low: counter++. When the low-sample count reaches DBL_GAP_CYC, assert short_pulse the next cycle and go to IDLE.
  - GAP, rise: go to PRESS2 with counter=1.
  - PRESS2, fall before LONG_CYC high samples: assert double_pulse the next cycle and go to IDLE.
  - PRESS2, high-sample count reaches LONG_CYC: assert long_pulse and go to LONG_HELD. No double_pulse is issued and the first press is discarded.
  - LONG_HELD: held=1. On fall, held drops the next cycle and the FSM goes to IDLE. No further event is issued.
- busy = (state != IDLE), registered.
- The counter saturates and never wraps. It is cleared on every state change.
- en low:
  - Synchronous: on the next edge, FSM=IDLE, counter=0, and all outputs=0.
  - din_q keeps tracking din, so a button already held when en rises does not generate a rise.
  - A fall and an event landing on the same edge that en goes low: en wins, no pulse.
- Reset mid-operation: the asynchronous clear takes effect immediately and any partially classified press is discarded.
- A rise in IDLE on the same edge that a short_pulse is emitted cannot occur, because GAP to IDLE requires din low. No further coincidence cases exist.

Test Plan (LONG_CYC=8, DBL_GAP_CYC=4, CNT_W=4):
- Reset with din=1, release rst_, en=1, keep din high for 20 cycles -> no pulses, busy=0 (no rise seen).
- din high 3 samples then low -> short_pulse=1 for exactly one cycle, in the cycle after the 4th low sample. busy falls together with it. No other pulse.
- din high 8 samples -> long_pulse one cycle after the 8th high sample. held=1 until the cycle after din falls. No short_pulse afterwards.
- din high 2, low 2, high 2, low -> double_pulse one cycle after the first low sample of the second press. No short_pulse.
- din high 2, low 3, high 10 -> long_pulse after the 8th high sample of the second press, held=1, no double_pulse. Then gap=4 exactly: din high 2, low 4, high 2 -> short_pulse, then a new PRESS1.
- Mid-PRESS1 drop en for 1 cycle -> busy=0, no pulse. Also assert rst_=0 asynchronously mid-GAP -> all outputs 0 immediately, and no event after release.
